// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU blocks.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } serial_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/adderSubtractor.sv
// One-bit adder/subtractor cell: S/Cout of A + (B ^ subtract) + Cin.
module adderSubtractor (
  input  logic A,
  input  logic B,
  input  logic Cin,
  input  logic subtract,
  output logic S,
  output logic Cout
);

  logic b_eff;

  assign b_eff = B ^ subtract;
  assign S     = A ^ b_eff ^ Cin;
  assign Cout  = (A & b_eff) | (Cin & (A ^ b_eff));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract sequencer: feeds the one-bit cell LSB first,
// keeps the ripple carry in a flop and produces the result with NZCV flags.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  serial_state_t    state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             sub_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  alu_flags_t       flags_q;

  logic sum;
  logic cout;

  adderSubtractor u_cell (
    .A        (a_sh_q[0]),
    .B        (b_sh_q[0]),
    .Cin      (carry_q),
    .subtract (sub_q),
    .S        (sum),
    .Cout     (cout)
  );

  // Control FSM plus datapath registers; busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            a_sh_q   <= a;
            b_sh_q   <= b;
            sub_q    <= subtract;
            carry_q  <= subtract;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          result_q <= {sum, result_q[WIDTH-1:1]};
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          carry_q  <= cout;
          if (cnt_q == LAST) begin
            // carry_q here is the carry into the MSB, so V = Cin(msb) ^ Cout(msb)
            flags_q.n <= sum;
            flags_q.z <= (result_q[WIDTH-1:1] == '0) && !sum;
            flags_q.c <= cout;
            flags_q.v <= carry_q ^ cout;
            state_q   <= DONE;
            done_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag_n = flags_q.n;
  assign flag_z = flags_q.z;
  assign flag_c = flags_q.c;
  assign flag_v = flags_q.v;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: stimulus pushes expected results,
// a monitor pops and compares whenever done is presented.
module tb_serial_addsub;

  localparam int unsigned W = 64;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   nzcv;
    int unsigned  done_cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         subtract;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         flag_n, flag_z, flag_c, flag_v;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .subtract (subtract),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_v   (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (result !== e.res) begin
          errors++;
          $display("FAIL result: got %h expected %h", result, e.res);
        end
        checks++;
        if ({flag_n, flag_z, flag_c, flag_v} !== e.nzcv) begin
          errors++;
          $display("FAIL nzcv: got %b expected %b", {flag_n, flag_z, flag_c, flag_v}, e.nzcv);
        end
        checks++;
        if (cyc != e.done_cyc) begin
          errors++;
          $display("FAIL latency: done at cycle %0d expected %0d", cyc, e.done_cyc);
        end
      end
    end
  end

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (result !== '0 || {flag_n, flag_z, flag_c, flag_v} !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: result=%h nzcv=%b busy=%b done=%b expected all zero",
               name, result, {flag_n, flag_z, flag_c, flag_v}, busy, done);
    end
  endtask

  // Issue one operation; optionally keep start high and scramble operands while it runs.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic sub,
                        input logic [W-1:0] exp_res, input logic [3:0] exp_nzcv, input bit hold);
    exp_t e;
    int unsigned n;
    bit seen;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    start    = 1'b1;
    subtract = sub;
    a        = op_a;
    b        = op_b;
    e.res      = exp_res;
    e.nzcv     = exp_nzcv;
    e.done_cyc = cyc + 1 + W;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      start    = hold;
      subtract = $urandom_range(0, 1);
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done=0 after 100 cycles expected 1");
    end
    @(negedge clk);
    start = 1'b0;
    check_bit("busy_after_done", busy, 1'b0);
    check_bit("done_pulse_width", done, 1'b0);
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    subtract = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;

    run_op(64'd5, 64'd3, 1'b0, 64'd8, 4'b0000, 1'b0);
    run_op(64'd5, 64'd5, 1'b1, 64'd0, 4'b0110, 1'b0);
    run_op(64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0);

    // start held high with changing operands: only the first op may complete
    run_op(64'd10, 64'd20, 1'b0, 64'd30, 4'b0000, 1'b1);
    repeat (5) @(negedge clk);
    check_bit("no_requeue_busy", busy, 1'b0);

    // reset 20 cycles into an operation
    start    = 1'b1;
    subtract = 1'b0;
    a        = 64'hFFFF_FFFF_FFFF_FFFF;
    b        = 64'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_bit("busy_mid_op", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'd7, 64'd2, 1'b1, 64'd5, 4'b0010, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
